// File: rtl/load_store_unit_if.sv
// Core/bus signal bundle for load_store_unit. master = core + memory side, slave = the LSU.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_ctrl;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              bus_valid;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_wdata;
  logic              bus_ready;
  logic [31:0]       bus_rdata;

  modport master (
    output req_valid, req_we, req_ctrl, req_addr, req_wdata, bus_ready, bus_rdata,
    input  stall, rsp_valid, rsp_rdata, rsp_err, bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata
  );

  modport slave (
    input  req_valid, req_we, req_ctrl, req_addr, req_wdata, bus_ready, bus_rdata,
    output stall, rsp_valid, rsp_rdata, rsp_err, bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory load/store unit: byte strobes, load extension, core stall, misalign/timeout errors.
// Define LSU_MISALIGN_SPLIT_EN to run misaligned HW/W accesses as two bus beats instead of erroring.
module load_store_unit #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave lsu
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} sz_e;

  typedef struct packed {
    logic       we;
    sz_e        sz;
    logic       uns;
    logic       mis;
    logic [1:0] off;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
`ifdef LSU_MISALIGN_SPLIT_EN
    , BUS2 = 2'd3
`endif
  } state_e;

  state_e            state, state_d;
  cmd_t              cmd_d, cmd_q;
  logic [7:0]        strb8;
  logic [31:0]       wd_rep, wd_rot;
  logic [63:0]       wd_dbl;
  logic [CNT_W-1:0]  cnt;
  logic              tmo_hit, in_bus, err_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_wstrb_q, strb_hi;
  logic [31:0]       wdata_q, rdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]       rd_lo;
`endif

  // Lane select + extension; beat-2 word sits in the upper half for split loads.
  function automatic logic [31:0] load_ext(input logic [63:0] pair, input cmd_t c);
    logic [63:0] sh;
    sh = pair >> {c.off, 3'b000};
    case (c.sz)
      SZ_B:    load_ext = c.uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_ext = c.uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_ext = sh[31:0];
    endcase
  endfunction

  always_comb begin
    cmd_d     = '0;
    cmd_d.sz  = SZ_W;
    cmd_d.we  = lsu.req_we;
    cmd_d.off = lsu.req_addr[1:0];
    if (lsu.req_we) begin
      case (lsu.req_ctrl)
        3'd0:    cmd_d.sz = SZ_B;
        3'd1:    cmd_d.sz = SZ_H;
        default: cmd_d.sz = SZ_W;
      endcase
    end else begin
      case (lsu.req_ctrl)
        3'd0, 3'd4: cmd_d.sz = SZ_B;
        3'd1, 3'd5: cmd_d.sz = SZ_H;
        default:    cmd_d.sz = SZ_W;
      endcase
    end
    cmd_d.uns = !lsu.req_we && (lsu.req_ctrl == 3'd4 || lsu.req_ctrl == 3'd5);
    cmd_d.mis = (cmd_d.sz == SZ_H && cmd_d.off[0]) || (cmd_d.sz == SZ_W && cmd_d.off != 2'd0);
    strb8  = 8'b0000_1111;
    wd_rep = lsu.req_wdata;
    case (cmd_d.sz)
      SZ_B: begin
        strb8  = 8'b0000_0001 << cmd_d.off;
        wd_rep = {4{lsu.req_wdata[7:0]}};
      end
      SZ_H: begin
        strb8  = 8'b0000_0011 << cmd_d.off;
        wd_rep = {2{lsu.req_wdata[15:0]}};
      end
      default: begin
        strb8  = 8'b0000_1111 << cmd_d.off;
        wd_rep = lsu.req_wdata;
      end
    endcase
    // Rotated data lands every byte in its lane for both beats of a split store.
    wd_dbl = {lsu.req_wdata, lsu.req_wdata} << {cmd_d.off, 3'b000};
    wd_rot = wd_dbl[63:32];
  end

  assign tmo_hit = (TIMEOUT_CYC > 0) && (cnt == CNT_MAX);

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (lsu.req_valid) state_d = (cmd_d.mis && !SPLIT) ? RESP : BUS;
      BUS: begin
        if (lsu.bus_ready) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = cmd_q.mis ? BUS2 : RESP;
`else
          state_d = RESP;
`endif
        end else if (tmo_hit) begin
          state_d = RESP;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BUS2: if (lsu.bus_ready || tmo_hit) state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      cnt         <= '0;
      err_q       <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      strb_hi     <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      rd_lo       <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (lsu.req_valid) begin
          cmd_q       <= cmd_d;
          cnt         <= '0;
          err_q       <= cmd_d.mis && !SPLIT;
          bus_addr_q  <= {lsu.req_addr[ADDR_W-1:2], 2'b00};
          bus_wstrb_q <= strb8[3:0];
          strb_hi     <= strb8[7:4];
          wdata_q     <= (SPLIT && cmd_d.mis) ? wd_rot : wd_rep;
        end
        BUS: begin
          cnt <= cnt + 1'b1;
          if (lsu.bus_ready) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            rd_lo <= lsu.bus_rdata;
`endif
            if (SPLIT && cmd_q.mis) begin
              bus_addr_q  <= bus_addr_q + ADDR_W'(4);
              bus_wstrb_q <= strb_hi;
              cnt         <= '0;
            end else if (!cmd_q.we) begin
              rdata_q <= load_ext({lsu.bus_rdata, lsu.bus_rdata}, cmd_q);
            end
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        BUS2: begin
          cnt <= cnt + 1'b1;
          if (lsu.bus_ready) begin
            if (!cmd_q.we) rdata_q <= load_ext({lsu.bus_rdata, rd_lo}, cmd_q);
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end
        end
`endif
        default: cnt <= '0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign in_bus = (state == BUS) || (state == BUS2);
`else
  assign in_bus = (state == BUS);
`endif

  assign lsu.stall     = (state == IDLE && lsu.req_valid) || in_bus;
  assign lsu.bus_valid = in_bus;
  assign lsu.bus_we    = in_bus && cmd_q.we;
  assign lsu.bus_addr  = bus_addr_q;
  assign lsu.bus_wstrb = bus_wstrb_q;
  assign lsu.bus_wdata = wdata_q;
  assign lsu.rsp_valid = (state == RESP);
  assign lsu.rsp_err   = (state == RESP) && err_q;
  assign lsu.rsp_rdata = rdata_q;

endmodule
